pmp_burst_checker: RTL and testbench



---
 rtl/pmp_burst_pkg.sv | 18 +
 rtl/pmp_burst_checker_if.sv | 39 +++
 rtl/pmp_burst_range.sv | 66 ++++++
 rtl/pmp_burst_checker.sv | 117 +++++++++++
 tb/tb_pmp_burst_checker.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmp_burst_pkg.sv
// Shared constants and types for the PMP burst range checker.
package pmp_burst_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Address bits below this index select a byte inside one 4 KiB page.
  localparam int unsigned PAGE_SHIFT = 12;

  typedef enum logic [1:0] {
    IDLE,
    CHK_LO,
    CHK_HI,
    RESP
  } state_e;

endpackage

// File: rtl/pmp_burst_checker_if.sv
// Request, PMP-probe and response signals of the burst checker.
// The slave view is the checker itself; the master view is its environment.
interface pmp_burst_checker_if #(
  parameter int unsigned PLEN         = 56,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned NrPmpEntries = 16
);
  localparam int unsigned IdxWidth = (NrPmpEntries > 1) ? $clog2(NrPmpEntries) : 1;

  logic                req_valid_i;
  logic                req_ready_o;
  logic [PLEN-1:0]     req_addr_i;
  logic [7:0]          req_len_i;
  logic [2:0]          req_size_i;
  logic [1:0]          req_burst_i;
  logic [IdWidth-1:0]  req_id_i;

  logic [PLEN-1:0]     pmp_addr_o;
  logic                pmp_allow_i;
  logic [IdxWidth-1:0] pmp_idx_i;

  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic                rsp_allow_o;
  logic [IdWidth-1:0]  rsp_id_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, req_size_i, req_burst_i, req_id_i,
    input  pmp_allow_i, pmp_idx_i, rsp_ready_i,
    output req_ready_o, pmp_addr_o, rsp_valid_o, rsp_allow_o, rsp_id_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_len_i, req_size_i, req_burst_i, req_id_i,
    output pmp_allow_i, pmp_idx_i, rsp_ready_i,
    input  req_ready_o, pmp_addr_o, rsp_valid_o, rsp_allow_o, rsp_id_o
  );

endinterface

// File: rtl/pmp_burst_range.sv
// Combinational conversion of an AXI burst into its lowest and highest byte
// address, plus a flag for bursts that can never be permitted.
module pmp_burst_range
  import pmp_burst_pkg::*;
#(
  parameter int unsigned PLEN = 56
) (
  input  logic [PLEN-1:0] i_addr,
  input  logic [7:0]      i_len,
  input  logic [2:0]      i_size,
  input  logic [1:0]      i_burst,
  output logic [PLEN-1:0] o_lo,
  output logic [PLEN-1:0] o_hi,
  output logic            o_illegal
);

  // One extra bit so the carry out of the top address bit stays visible.
  localparam logic [PLEN:0] LP_ONE = (PLEN+1)'(1);

  logic [PLEN:0] w_addrWide;
  logic [PLEN:0] w_beatBytes;
  logic [PLEN:0] w_totalBytes;
  logic [PLEN:0] w_aligned;
  logic [PLEN:0] w_wrapLo;
  logic [PLEN:0] w_loWide;
  logic [PLEN:0] w_hiWide;
  logic          w_wrapLenBad;
  logic          w_wrapMisaligned;
  logic          w_carry;
  logic          w_pageCross;

  assign w_addrWide   = {1'b0, i_addr};
  assign w_beatBytes  = LP_ONE << i_size;
  assign w_totalBytes = ((PLEN+1)'(i_len) + LP_ONE) << i_size;
  assign w_aligned    = w_addrWide & ~(w_beatBytes - LP_ONE);
  assign w_wrapLo     = w_addrWide & ~(w_totalBytes - LP_ONE);

  // Endpoint selection per burst type; the reserved type falls back to INCR
  // arithmetic because it is flagged illegal anyway.
  always_comb begin
    w_loWide = w_addrWide;
    w_hiWide = w_aligned + w_totalBytes - LP_ONE;
    case (i_burst)
      BURST_FIXED: w_hiWide = w_aligned + w_beatBytes - LP_ONE;
      BURST_WRAP: begin
        w_loWide = w_wrapLo;
        w_hiWide = w_wrapLo + w_totalBytes - LP_ONE;
      end
      default: ;
    endcase
  end

  assign w_wrapLenBad     = !(i_len inside {8'd1, 8'd3, 8'd7, 8'd15});
  assign w_wrapMisaligned = (w_addrWide & (w_beatBytes - LP_ONE)) != '0;
  assign w_carry          = w_hiWide[PLEN];
  assign w_pageCross      = w_loWide[PLEN-1:PAGE_SHIFT] != w_hiWide[PLEN-1:PAGE_SHIFT];

  assign o_lo      = w_loWide[PLEN-1:0];
  assign o_hi      = w_hiWide[PLEN-1:0];
  assign o_illegal = (i_burst == 2'b11)
                   || (i_size > 3'd3)
                   || ((i_burst == BURST_WRAP) && (w_wrapLenBad || w_wrapMisaligned))
                   || w_carry
                   || w_pageCross;

endmodule

// File: rtl/pmp_burst_checker.sv
// Checks one AXI burst at a time against the PMP stage by probing its lowest
// and then its highest byte address, and returns a single allow/deny decision.
module pmp_burst_checker
  import pmp_burst_pkg::*;
#(
  parameter int unsigned PLEN         = 56,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned NrPmpEntries = 16
) (
  input logic                clk_i,
  input logic                rst_ni,
  pmp_burst_checker_if.slave bus
);

  localparam int unsigned IdxWidth = (NrPmpEntries > 1) ? $clog2(NrPmpEntries) : 1;

  state_e              r_state;
  state_e              w_nextState;
  logic                w_accept;
  logic                w_reqReady;
  logic                w_rspValid;
  logic [PLEN-1:0]     w_pmpAddr;

  logic [PLEN-1:0]     w_lo;
  logic [PLEN-1:0]     w_hi;
  logic                w_illegal;

  logic [IdWidth-1:0]  r_id;
  logic [PLEN-1:0]     r_lo;
  logic [PLEN-1:0]     r_hi;
  logic                r_illegal;
  logic                r_allowLo;
  logic [IdxWidth-1:0] r_idxLo;
  logic                r_rspAllow;

  pmp_burst_range #(.PLEN(PLEN)) u_range (
    .i_addr    (bus.req_addr_i),
    .i_len     (bus.req_len_i),
    .i_size    (bus.req_size_i),
    .i_burst   (bus.req_burst_i),
    .o_lo      (w_lo),
    .o_hi      (w_hi),
    .o_illegal (w_illegal)
  );

  // State register; reset drops any request in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next state and outputs; both probes always run so latency never varies.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_reqReady  = 1'b0;
    w_rspValid  = 1'b0;
    w_pmpAddr   = '0;
    case (r_state)
      IDLE: begin
        w_reqReady = 1'b1;
        if (bus.req_valid_i) begin
          w_accept    = 1'b1;
          w_nextState = CHK_LO;
        end
      end
      CHK_LO: begin
        w_pmpAddr   = r_lo;
        w_nextState = CHK_HI;
      end
      CHK_HI: begin
        w_pmpAddr   = r_hi;
        w_nextState = RESP;
      end
      RESP: begin
        w_rspValid = 1'b1;
        if (bus.rsp_ready_i) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Request capture, low-end probe result, and the final decision, which
  // requires both endpoints to hit the same entry so the burst sits in one region.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id       <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_illegal  <= 1'b0;
      r_allowLo  <= 1'b0;
      r_idxLo    <= '0;
      r_rspAllow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_id      <= bus.req_id_i;
        r_lo      <= w_lo;
        r_hi      <= w_hi;
        r_illegal <= w_illegal;
      end
      if (r_state == CHK_LO) begin
        r_allowLo <= bus.pmp_allow_i;
        r_idxLo   <= bus.pmp_idx_i;
      end
      if (r_state == CHK_HI) begin
        r_rspAllow <= r_allowLo & bus.pmp_allow_i & (r_idxLo == bus.pmp_idx_i) & ~r_illegal;
      end
    end
  end

  assign bus.req_ready_o = w_reqReady;
  assign bus.rsp_valid_o = w_rspValid;
  assign bus.pmp_addr_o  = w_pmpAddr;
  assign bus.rsp_allow_o = r_rspAllow;
  assign bus.rsp_id_o    = r_id;

endmodule

// File: tb/tb_pmp_burst_checker.sv
// Scoreboard bench for pmp_burst_checker: a driver issues directed and random
// bursts and queues the expected decision from a reference model; a monitor
// follows the probe/response sequence and compares against the queue head.
module tb_pmp_burst_checker;
  import pmp_burst_pkg::*;

  localparam int unsigned PLEN         = 56;
  localparam int unsigned IdWidth      = 4;
  localparam int unsigned NrPmpEntries = 16;
  localparam longint unsigned ADDR_LIMIT = 64'd1 << PLEN;

  typedef struct packed {
    logic [3:0]  id;
    logic        allow;
    logic [55:0] lo;
    logic [55:0] hi;
    logic        checkAddr;
  } expItem_t;

  logic clk_i = 1'b0;
  logic rst_ni;

  expItem_t expQ[$];
  int testsRun = 0;
  int testsFailed = 0;

  logic [15:0] regionAllow;
  logic        ov0En, ov1En;
  logic [55:0] ov0Addr, ov1Addr;
  logic        ov0Allow, ov1Allow;
  logic [3:0]  ov0Idx, ov1Idx;
  logic        holdOff;
  logic        pmpAllow;
  logic [3:0]  pmpIdx;

  pmp_burst_checker_if #(.PLEN(PLEN), .IdWidth(IdWidth), .NrPmpEntries(NrPmpEntries)) bus ();

  pmp_burst_checker #(.PLEN(PLEN), .IdWidth(IdWidth), .NrPmpEntries(NrPmpEntries)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  // PMP stage model: 16 regions of 2 KiB from address 0, entry i at i*0x800,
  // plus two exact-address overrides (override 0 wins).
  function automatic void pmpModel(input logic [55:0] a, output logic allow, output logic [3:0] idx);
    allow = 1'b0;
    idx   = 4'd0;
    if (a < 56'h8000) begin
      idx   = a[14:11];
      allow = regionAllow[a[14:11]];
    end
    if (ov1En && a == ov1Addr) begin
      allow = ov1Allow;
      idx   = ov1Idx;
    end
    if (ov0En && a == ov0Addr) begin
      allow = ov0Allow;
      idx   = ov0Idx;
    end
  endfunction

  always_comb begin
    pmpAllow = 1'b0;
    pmpIdx   = 4'd0;
    pmpModel(bus.pmp_addr_o, pmpAllow, pmpIdx);
  end

  assign bus.pmp_allow_i = pmpAllow;
  assign bus.pmp_idx_i   = pmpIdx;

  // Reference for the touched byte range using ordinary integer arithmetic.
  function automatic void refRange(input logic [55:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst,
                                   output logic [55:0] lo, output logic [55:0] hi,
                                   output logic bad);
    longint unsigned a, beat, total, base, top;
    a     = 64'(addr);
    beat  = 64'd1 << size;
    total = (64'(len) + 64'd1) * beat;
    bad   = 1'b0;
    base  = a;
    top   = (a / beat) * beat + total - 64'd1;
    if (burst == BURST_FIXED) begin
      top = (a / beat) * beat + beat - 64'd1;
    end else if (burst == BURST_WRAP) begin
      base = a & ~(total - 64'd1);
      top  = base + total - 64'd1;
      if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) bad = 1'b1;
      if (a % beat != 64'd0) bad = 1'b1;
    end else if (burst == 2'b11) begin
      bad = 1'b1;
    end
    if (size > 3'd3) bad = 1'b1;
    if (top >= ADDR_LIMIT) bad = 1'b1;
    lo = 56'(base);
    hi = 56'(top);
    if ((lo >> 12) != (hi >> 12)) bad = 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic finishSim();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  endtask

  // Issue one burst; the expected decision is queued when the handshake happens.
  task automatic applyStimulus(input logic [55:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [3:0] id, input int dirAllow);
    expItem_t e;
    logic lo_, hi_;
    logic [3:0] idxLo, idxHi;
    logic bad;
    logic accepted;
    refRange(addr, len, size, burst, e.lo, e.hi, bad);
    pmpModel(e.lo, lo_, idxLo);
    pmpModel(e.hi, hi_, idxHi);
    e.allow     = !bad && lo_ && hi_ && (idxLo == idxHi);
    if (dirAllow >= 0) e.allow = (dirAllow != 0);
    e.id        = id;
    e.checkAddr = (burst != 2'b11);
    @(posedge clk_i);
    #1;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_len_i   = len;
    bus.req_size_i  = size;
    bus.req_burst_i = burst;
    bus.req_id_i    = id;
    accepted = 1'b0;
    for (int w = 0; w < 50 && !accepted; w++) begin
      @(negedge clk_i);
      if (bus.req_ready_o) accepted = 1'b1;
    end
    if (accepted) expQ.push_back(e);
    else checkOutput("accept_timeout", 64'(accepted), 64'd1);
    @(posedge clk_i);
    #1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 56'({$urandom(), $urandom()});
    bus.req_len_i   = 8'($urandom());
    bus.req_size_i  = 3'($urandom());
    bus.req_burst_i = 2'($urandom());
    bus.req_id_i    = 4'($urandom());
  endtask

  task automatic waitIdle();
    for (int w = 0; w < 100 && expQ.size() != 0; w++) @(negedge clk_i);
    if (expQ.size() != 0) begin
      checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
      expQ.delete();
    end
  endtask

  // Response-ready generator: random, unless the driver forces backpressure.
  initial begin
    bus.rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      bus.rsp_ready_i = holdOff ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: idle -> probe lo -> probe hi -> response, as seen from the pins.
  initial begin
    int phase;
    expItem_t cur;
    phase = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        expQ.delete();
        phase = 0;
        continue;
      end
      case (phase)
        0: begin
          checkOutput("idle_req_ready", 64'(bus.req_ready_o), 64'd1);
          checkOutput("idle_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
          checkOutput("idle_pmp_addr", 64'(bus.pmp_addr_o), 64'd0);
          if (bus.req_valid_i && bus.req_ready_o) phase = 1;
        end
        1, 2: begin
          if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd1);
            phase = 0;
          end else begin
            cur = expQ[0];
            if (cur.checkAddr)
              checkOutput(phase == 1 ? "pmp_addr_lo" : "pmp_addr_hi", 64'(bus.pmp_addr_o),
                          64'(phase == 1 ? cur.lo : cur.hi));
            checkOutput("busy_req_ready", 64'(bus.req_ready_o), 64'd0);
            checkOutput("busy_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
            phase = phase + 1;
          end
        end
        default: begin
          checkOutput("rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
          if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd1);
            phase = 0;
          end else if (!bus.rsp_valid_o) begin
            void'(expQ.pop_front());
            phase = 0;
          end else begin
            cur = expQ[0];
            checkOutput("rsp_allow", 64'(bus.rsp_allow_o), 64'(cur.allow));
            checkOutput("rsp_id", 64'(bus.rsp_id_o), 64'(cur.id));
            checkOutput("resp_req_ready", 64'(bus.req_ready_o), 64'd0);
            checkOutput("resp_pmp_addr", 64'(bus.pmp_addr_o), 64'd0);
            if (bus.rsp_ready_i) begin
              void'(expQ.pop_front());
              phase = 0;
            end
          end
        end
      endcase
    end
  end

  initial begin
    #500000;
    checkOutput("watchdog", 64'd0, 64'd1);
    finishSim();
  end

  // Driver: reset values, directed cases, backpressure, mid-flight reset, random mix.
  initial begin
    logic [55:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [1:0]  burst;
    int sel;
    logic seenValid;

    rst_ni = 1'b0;
    holdOff = 1'b0;
    regionAllow = 16'hFFFF;
    ov0En = 1'b0; ov1En = 1'b0;
    ov0Addr = '0; ov1Addr = '0;
    ov0Allow = 1'b0; ov1Allow = 1'b0;
    ov0Idx = '0; ov1Idx = '0;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_len_i   = '0;
    bus.req_size_i  = '0;
    bus.req_burst_i = '0;
    bus.req_id_i    = '0;

    #12;
    checkOutput("reset_req_ready", 64'(bus.req_ready_o), 64'd1);
    checkOutput("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    checkOutput("reset_rsp_allow", 64'(bus.rsp_allow_o), 64'd0);
    checkOutput("reset_rsp_id", 64'(bus.rsp_id_o), 64'd0);
    checkOutput("reset_pmp_addr", 64'(bus.pmp_addr_o), 64'd0);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;

    applyStimulus(56'h1000, 8'd3, 3'd3, BURST_INCR, 4'h1, 1);
    waitIdle();

    ov0En = 1'b1; ov0Addr = 56'h101F; ov0Allow = 1'b0; ov0Idx = 4'd2;
    applyStimulus(56'h1018, 8'd3, 3'd3, BURST_WRAP, 4'h2, 0);
    waitIdle();
    ov0En = 1'b0;

    applyStimulus(56'h0FF8, 8'd1, 3'd3, BURST_INCR, 4'h3, 0);
    waitIdle();

    ov0En = 1'b1; ov0Addr = 56'h2004; ov0Allow = 1'b1; ov0Idx = 4'd1;
    ov1En = 1'b1; ov1Addr = 56'h2007; ov1Allow = 1'b1; ov1Idx = 4'd3;
    applyStimulus(56'h2004, 8'd0, 3'd2, BURST_FIXED, 4'h4, 0);
    waitIdle();
    ov1Idx = 4'd1;
    applyStimulus(56'h2004, 8'd0, 3'd2, BURST_FIXED, 4'h5, 1);
    waitIdle();
    ov0En = 1'b0; ov1En = 1'b0;

    holdOff = 1'b1;
    applyStimulus(56'h3100, 8'd7, 3'd2, BURST_INCR, 4'h6, -1);
    seenValid = 1'b0;
    for (int w = 0; w < 10 && !seenValid; w++) begin
      @(negedge clk_i);
      seenValid = bus.rsp_valid_o;
    end
    checkOutput("backpressure_rsp_seen", 64'(seenValid), 64'd1);
    repeat (4) @(negedge clk_i);
    holdOff = 1'b0;
    waitIdle();

    applyStimulus(56'h4000, 8'd1, 3'd2, BURST_INCR, 4'hD, -1);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    checkOutput("midreset_req_ready", 64'(bus.req_ready_o), 64'd1);
    checkOutput("midreset_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    checkOutput("midreset_pmp_addr", 64'(bus.pmp_addr_o), 64'd0);
    @(negedge clk_i);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    waitIdle();

    for (int n = 0; n < 250; n++) begin
      waitIdle();
      regionAllow = 16'($urandom() | $urandom());
      sel = $urandom_range(0, 9);
      if (sel < 5)      addr = 56'($urandom_range(0, 32'h7FFF));
      else if (sel < 7) addr = 56'($urandom_range(1, 8) * 4096 - $urandom_range(0, 64));
      else if (sel < 8) addr = 56'(ADDR_LIMIT - 64'($urandom_range(1, 256)));
      else              addr = 56'({$urandom(), $urandom()});
      size  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      len   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      sel   = $urandom_range(0, 9);
      burst = (sel < 3) ? BURST_FIXED : (sel < 7) ? BURST_INCR : (sel < 9) ? BURST_WRAP : 2'b11;
      if (burst == BURST_WRAP && $urandom_range(0, 3) != 0) begin
        addr = addr & ~((56'd1 << size) - 56'd1);
        if ($urandom_range(0, 1) == 0) len = 8'((2 << $urandom_range(0, 3)) - 1);
      end
      applyStimulus(addr, len, size, burst, 4'($urandom()), -1);
    end
    waitIdle();
    repeat (3) @(negedge clk_i);
    finishSim();
  end

endmodule
